// File: rtl/exec_ctrl_pkg.sv
// exec_ctrl_pkg: processor run/debug sequencer state encoding and default parameter values
package exec_ctrl_pkg;
  typedef enum logic [2:0] {OFF = 3'd0, RUN = 3'd1, DBG_WAIT = 3'd2, DBG_STEP = 3'd3, HALT = 3'd4} exec_state_t;
  localparam logic [31:0] DEF_END_PC = 32'h0000_00FC;
  localparam int DEF_DEB_CYCLES = 500000;
endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: 2-flop sync + debounce of btn, step_req pulses one clk on each debounced rising edge (clk, rst active-low async, btn, step_req)
module button_debouncer import exec_ctrl_pkg::*; #(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic step_req
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic db, db_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync <= '0;
      cnt <= '0;
      db <= 1'b0;
      db_q <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      db_q <= db;
      if (sync[1] == db) cnt <= '0;
      else if (cnt == CW'(DEB_CYCLES - 1)) begin
        db <= sync[1];
        cnt <= '0;
      end else cnt <= cnt + CW'(1);
    end
  assign step_req = db & ~db_q;
endmodule

// File: rtl/exec_controller.sv
// exec_controller: glitch-free processor clock enable with free-run, single-step and halt at END_PC (clk, rst active-low async, pwr/dbg/stp async inputs, pc; run_en, halted, cycle_count, state_led, out)
module exec_controller import exec_ctrl_pkg::*; #(
  parameter int N = 32,
  parameter logic [N-1:0] END_PC = N'(DEF_END_PC),
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int STEP_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic pwr,
  input  logic dbg,
  input  logic stp,
  input  logic [N-1:0] pc,
  output logic run_en,
  output logic halted,
  output logic [N-1:0] cycle_count,
  output logic [2:0] state_led,
  output logic out
);
  exec_state_t state;
  logic [1:0] pwr_sync, dbg_sync;
  logic pwr_prev, pwr_fall, step_req;
  logic [7:0] step_cnt;
  button_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_stp (.clk(clk), .rst(rst), .btn(stp), .step_req(step_req));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pwr_sync <= '0;
      dbg_sync <= '0;
      pwr_prev <= 1'b0;
      pwr_fall <= 1'b0;
      step_cnt <= '0;
      cycle_count <= '0;
      state <= OFF;
    end else begin
      pwr_sync <= {pwr_sync[0], pwr};
      dbg_sync <= {dbg_sync[0], dbg};
      pwr_prev <= pwr_sync[1];
      pwr_fall <= pwr_prev & ~pwr_sync[1];
      if (run_en && cycle_count != '1) cycle_count <= cycle_count + N'(1);
      case (state)
        OFF: if (pwr_fall) state <= dbg_sync[1] ? DBG_WAIT : RUN;
        RUN:
          if (pc == END_PC) state <= HALT;
          else if (dbg_sync[1]) state <= DBG_WAIT;
        DBG_WAIT:
          if (!dbg_sync[1]) state <= RUN;
          else if (step_req) begin
            state <= DBG_STEP;
            step_cnt <= 8'(STEP_CYCLES - 1);
          end
        DBG_STEP:
          if (pc == END_PC) state <= HALT;
          else if (step_cnt == 8'd0) state <= DBG_WAIT;
          else step_cnt <= step_cnt - 8'd1;
        default: ;
      endcase
    end
  // encoding puts RUN/DBG_STEP on bit 0 and HALT on bit 2, so both enables are single flop outputs
  assign run_en = state[0];
  assign halted = state[2];
  assign state_led = state;
  assign out = run_en | halted;
endmodule

// File: tb/tb_exec_controller.sv
// tb_exec_controller: scoreboard bench for exec_controller (step bursts queued at press, popped when run_en burst ends)
module tb_exec_controller;
  logic clk = 1'b0;
  logic rst, pwr, dbg, stp, stp3;
  logic [31:0] pc;
  logic run_en, halted, out, run_en3, halted3, out3;
  logic [31:0] cycle_count, cycle_count3;
  logic [2:0] state_led, state_led3;
  int errors = 0, checks = 0;
  int q1[$], q3[$];
  int len1 = 0, len3 = 0;
  bit mon = 0;
  int base;
  exec_controller #(.N(32), .END_PC(32'hFC), .DEB_CYCLES(4), .STEP_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .pwr(pwr), .dbg(dbg), .stp(stp), .pc(pc), .run_en(run_en),
    .halted(halted), .cycle_count(cycle_count), .state_led(state_led), .out(out));
  exec_controller #(.N(32), .END_PC(32'hFC), .DEB_CYCLES(1), .STEP_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .pwr(pwr), .dbg(dbg), .stp(stp3), .pc(pc), .run_en(run_en3),
    .halted(halted3), .cycle_count(cycle_count3), .state_led(state_led3), .out(out3));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (run_en === 1'b1) len1++;
    else begin
      if (len1 != 0 && mon) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL burst1: unexpected run_en burst of %0d cycles", len1);
        end else if (len1 !== q1[0]) begin
          errors++;
          $display("FAIL burst1: got %0d cycles expected %0d", len1, q1[0]);
        end
        if (q1.size() != 0) void'(q1.pop_front());
      end
      len1 = 0;
    end
  end
  always @(negedge clk) begin
    if (run_en3 === 1'b1) len3++;
    else begin
      if (len3 != 0 && mon) begin
        checks++;
        if (q3.size() == 0) begin
          errors++;
          $display("FAIL burst3: unexpected run_en burst of %0d cycles", len3);
        end else if (len3 !== q3[0]) begin
          errors++;
          $display("FAIL burst3: got %0d cycles expected %0d", len3, q3[0]);
        end
        if (q3.size() != 0) void'(q3.pop_front());
      end
      len3 = 0;
    end
  end
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset();
    rst = 1'b0; pwr = 1'b1; dbg = 1'b0; stp = 1'b0; stp3 = 1'b0; pc = 32'h0;
    tick(3);
    rst = 1'b1;
    tick(5);
  endtask
  task automatic press(input int n);
    stp = 1'b1;
    tick(n);
    stp = 1'b0;
    tick(14);
  endtask
  task automatic test_reset();
    rst = 1'b0; pwr = 1'b1; dbg = 1'b0; stp = 1'b0; stp3 = 1'b0; pc = 32'h0;
    tick(3);
    checks++; if (run_en !== 1'b0) begin errors++; $display("FAIL reset_run_en: got %b expected 0", run_en); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
    checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", cycle_count); end
    checks++; if (state_led !== 3'd0) begin errors++; $display("FAIL reset_led: got %0d expected 0", state_led); end
    checks++; if (out !== 1'b0) begin errors++; $display("FAIL reset_out: got %b expected 0", out); end
    rst = 1'b1;
    tick(5);
    checks++; if (state_led !== 3'd0) begin errors++; $display("FAIL off_idle: got %0d expected 0", state_led); end
  endtask
  task automatic test_free_run();
    pwr = 1'b0;
    tick(3);
    checks++; if (run_en !== 1'b0) begin errors++; $display("FAIL run_early: got %b expected 0", run_en); end
    tick(1);
    checks++; if (run_en !== 1'b1) begin errors++; $display("FAIL run_latency: got %b expected 1", run_en); end
    tick(10);
    checks++; if (cycle_count !== 32'd10) begin errors++; $display("FAIL run_count: got %0d expected 10", cycle_count); end
    checks++; if (state_led !== 3'd1) begin errors++; $display("FAIL run_led: got %0d expected 1", state_led); end
  endtask
  task automatic test_halt();
    pc = 32'hFC;
    tick(1);
    checks++; if (state_led !== 3'd4) begin errors++; $display("FAIL halt_led: got %0d expected 4", state_led); end
    checks++; if (run_en !== 1'b0 || halted !== 1'b1 || out !== 1'b1) begin errors++; $display("FAIL halt_flags: got run_en=%b halted=%b out=%b expected 0 1 1", run_en, halted, out); end
    checks++; if (cycle_count !== 32'd11) begin errors++; $display("FAIL halt_count: got %0d expected 11", cycle_count); end
    pc = 32'h0; pwr = 1'b1;
    tick(6);
    pwr = 1'b0;
    tick(8);
    checks++; if (state_led !== 3'd4 || cycle_count !== 32'd11) begin errors++; $display("FAIL halt_sticky: got state %0d count %0d expected 4 11", state_led, cycle_count); end
  endtask
  task automatic test_debug_step();
    do_reset();
    dbg = 1'b1;
    tick(3);
    pwr = 1'b0;
    tick(4);
    checks++; if (state_led !== 3'd2 || run_en !== 1'b0) begin errors++; $display("FAIL dbg_wait: got state %0d run_en %b expected 2 0", state_led, run_en); end
    mon = 1;
    q1.push_back(1);
    press(6);
    checks++; if (cycle_count !== 32'd1) begin errors++; $display("FAIL step_one: got %0d expected 1", cycle_count); end
    repeat (2) begin
      q1.push_back(1);
      press(6);
    end
    checks++; if (cycle_count !== 32'd3) begin errors++; $display("FAIL step_three: got %0d expected 3", cycle_count); end
  endtask
  task automatic test_bounce();
    base = cycle_count;
    for (int i = 0; i < 20; i++) begin
      stp = ~stp;
      tick(1);
    end
    q1.push_back(1);
    press(10);
    checks++; if (cycle_count !== 32'(base + 1)) begin errors++; $display("FAIL bounce: got %0d expected %0d", cycle_count, base + 1); end
    press(3);
    checks++; if (cycle_count !== 32'(base + 1)) begin errors++; $display("FAIL short_pulse: got %0d expected %0d", cycle_count, base + 1); end
  endtask
  task automatic test_mode_switch();
    mon = 0;
    dbg = 1'b0;
    tick(2);
    checks++; if (run_en !== 1'b0) begin errors++; $display("FAIL resume_early: got %b expected 0", run_en); end
    tick(1);
    checks++; if (run_en !== 1'b1 || state_led !== 3'd1) begin errors++; $display("FAIL resume: got run_en %b state %0d expected 1 1", run_en, state_led); end
    dbg = 1'b1;
    tick(3);
    checks++; if (run_en !== 1'b0 || state_led !== 3'd2) begin errors++; $display("FAIL dbg_enter: got run_en %b state %0d expected 0 2", run_en, state_led); end
    tick(2);
    mon = 1;
    base = cycle_count3;
    q3.push_back(3);
    stp3 = 1'b1; tick(2); stp3 = 1'b0; tick(10);
    checks++; if (cycle_count3 !== 32'(base + 3)) begin errors++; $display("FAIL step3: got %0d expected %0d", cycle_count3, base + 3); end
    q3.push_back(3);
    stp3 = 1'b1; tick(1); stp3 = 1'b0; tick(1); stp3 = 1'b1; tick(1); stp3 = 1'b0;
    tick(12);
    checks++; if (cycle_count3 !== 32'(base + 6)) begin errors++; $display("FAIL step3_drop: got %0d expected %0d", cycle_count3, base + 6); end
  endtask
  task automatic test_reset_mid();
    mon = 0;
    stp3 = 1'b1; tick(1); stp3 = 1'b0;
    tick(3);
    checks++; if (state_led3 !== 3'd3 || run_en3 !== 1'b1) begin errors++; $display("FAIL mid_step: got state %0d run_en %b expected 3 1", state_led3, run_en3); end
    #2 rst = 1'b0;
    #1;
    checks++; if (run_en3 !== 1'b0 || state_led3 !== 3'd0 || cycle_count3 !== 32'd0) begin errors++; $display("FAIL async_reset: got run_en %b state %0d count %0d expected 0 0 0", run_en3, state_led3, cycle_count3); end
    checks++; if (cycle_count !== 32'd0 || state_led !== 3'd0) begin errors++; $display("FAIL async_reset1: got state %0d count %0d expected 0 0", state_led, cycle_count); end
    tick(2);
    rst = 1'b1;
    tick(8);
    checks++; if (state_led !== 3'd0 || state_led3 !== 3'd0) begin errors++; $display("FAIL post_reset_off: got %0d %0d expected 0 0", state_led, state_led3); end
    pwr = 1'b1;
    tick(5);
    pwr = 1'b0;
    tick(4);
    checks++; if (state_led !== 3'd2 || state_led3 !== 3'd2) begin errors++; $display("FAIL post_reset_dbg: got %0d %0d expected 2 2", state_led, state_led3); end
  endtask
  initial begin
    test_reset();
    test_free_run();
    test_halt();
    test_debug_step();
    test_bounce();
    test_mode_switch();
    test_reset_mid();
    checks++; if (q1.size() != 0 || q3.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0", q1.size(), q3.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
